// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals shared between uart_tx_sched and its environment.
// The slave modport is the scheduler's view; master is the driving side.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_ack_o;
    logic [NREQ-1:0]   grant_o;
    logic [7:0]        tx_data_o;
    logic              tx_start_o;
    logic              tx_busy_i;
    logic              err_timeout_o;

    modport slave (
        input  req_valid_i, req_data_i, tx_busy_i,
        output req_ack_o, grant_o, tx_data_o, tx_start_o, err_timeout_o
    );

    modport master (
        output req_valid_i, req_data_i, tx_busy_i,
        input  req_ack_o, grant_o, tx_data_o, tx_start_o, err_timeout_o
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers,
// with an inter-frame gap and a timeout on a transmitter that stalls.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int GAP     = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic           sysclk,
    input  logic           reset_n,
    uart_tx_sched_if.slave bus
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GMAX  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [PW-1:0] PLAST = PW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   last_q, last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            start_q, start_d;
    logic            err_q, err_d;

    logic [7:0]      req_byte [NREQ];
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [PW:0]     cand_sum;
    logic            frame_end;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_byte[gi] = bus.req_data_i[8*gi +: 8];
    end

    // Search last+1, last+2, ... with an explicit wrap so non-power-of-two NREQ works.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        cand_sum  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_sum = {1'b0, last_q} + (PW+1)'(i);
            if (cand_sum >= (PW+1)'(NREQ)) begin
                cand_sum = cand_sum - (PW+1)'(NREQ);
            end
            cand = cand_sum[PW-1:0];
            if (!win_found && bus.req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        grant_d   = grant_q;
        data_d    = data_q;
        ack_d     = '0;
        start_d   = 1'b0;
        err_d     = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found && !bus.tx_busy_i) begin
                    data_d  = req_byte[win_idx];
                    grant_d = NREQ'(1) << win_idx;
                    ack_d   = NREQ'(1) << win_idx;
                    start_d = 1'b1;
                    last_d  = win_idx;
                    timer_d = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy_i) begin
                    timer_d = '0;
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TMAX) begin
                    err_d     = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy_i) begin
                    frame_end = 1'b1;
                end else if (timer_q == TMAX) begin
                    err_d     = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GMAX) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                data_d  = '0;
            end
        endcase
        // Normal completion and timeout share the same exit; with no gap we skip straight to IDLE.
        if (frame_end) begin
            if (GAP == 0) begin
                state_d = ST_IDLE;
                grant_d = '0;
            end else begin
                state_d = ST_GAP;
                gap_d   = '0;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= PLAST;
            timer_q <= '0;
            gap_q   <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ack_o     = ack_q;
    assign bus.grant_o       = grant_q;
    assign bus.tx_data_o     = data_q;
    assign bus.tx_start_o    = start_q;
    assign bus.err_timeout_o = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: queued requesters, a behavioural transmitter,
// and a round-robin/timing reference model derived from the scheduling rules.
module tb_uart_tx_sched;
    localparam int NREQ    = 4;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 4096;
    localparam int BIG     = 1 << 30;
    localparam int QD      = 64;

    logic sysclk  = 1'b0;
    logic reset_n = 1'b1;

    uart_tx_sched_if #(.NREQ(NREQ)) bus ();

    uart_tx_sched #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .sysclk (sysclk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] grant;
        logic [7:0]      data;
        logic [NREQ-1:0] vseen;
        logic            start;
    } start_rec_t;

    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;
    start_rec_t      starts[$];
    int              err_edges[$];
    int              rise_edges[$];
    int              fall_edges[$];
    logic [NREQ-1:0] grant_log[$];

    // Requester byte queues, one per requester (stimulus side).
    logic [7:0]      bq [NREQ][QD];
    int              head [NREQ];
    int              tail [NREQ];

    // Transmitter model: 0 normal, 1 never busy, 2 busy stuck high.
    int              bm_mode;
    int              busy_len;
    int              busy_on_at;
    int              busy_off_at;
    bit              rand_len;
    logic            prev_busy;

    int              exp_w[$];
    logic [7:0]      exp_d[$];

    function automatic int rr_pick(logic [NREQ-1:0] v, int last);
        for (int d = 1; d <= NREQ; d++) begin
            if (v[(last + d) % NREQ]) return (last + d) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(int w);
        logic [NREQ-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic drive_reqs();
        for (int k = 0; k < NREQ; k++) begin
            bus.req_valid_i[k]       = (head[k] < tail[k]);
            bus.req_data_i[8*k +: 8] = (head[k] < tail[k]) ? bq[k][head[k]] : 8'h00;
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] b);
        bq[k][tail[k]] = b;
        tail[k]++;
        drive_reqs();
    endtask

    task automatic clear_model();
        for (int k = 0; k < NREQ; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        bm_mode       = 0;
        busy_len      = 4;
        rand_len      = 1'b0;
        busy_on_at    = BIG;
        busy_off_at   = BIG;
        bus.tx_busy_i = 1'b0;
        prev_busy     = 1'b0;
        drive_reqs();
    endtask

    task automatic tick();
        logic [NREQ-1:0] vseen;
        logic            bseen;
        start_rec_t      r;
        @(posedge sysclk);
        #1;
        cyc++;
        vseen = bus.req_valid_i;
        bseen = bus.tx_busy_i;
        if (bseen && !prev_busy) rise_edges.push_back(cyc);
        if (!bseen && prev_busy) fall_edges.push_back(cyc);
        prev_busy = bseen;
        grant_log.push_back(bus.grant_o);
        if (bus.tx_start_o || (|bus.req_ack_o)) begin
            r.cyc = cyc; r.ack = bus.req_ack_o; r.grant = bus.grant_o;
            r.data = bus.tx_data_o; r.vseen = vseen; r.start = bus.tx_start_o;
            starts.push_back(r);
            for (int k = 0; k < NREQ; k++) begin
                if (bus.req_ack_o[k] && head[k] < tail[k]) head[k]++;
            end
            if (rand_len) busy_len = int'($urandom_range(1, 12));
            if (bm_mode == 0) begin
                busy_on_at  = cyc + 1;
                busy_off_at = cyc + 1 + busy_len;
            end else if (bm_mode == 2) begin
                busy_on_at  = cyc + 1;
                busy_off_at = BIG;
            end
        end
        if (bus.err_timeout_o) err_edges.push_back(cyc);
        bus.tx_busy_i = (cyc >= busy_on_at) && (cyc < busy_off_at);
        drive_reqs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_model();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        int b;
        b = 0;
        while (starts.size() < n && b < budget) begin
            tick();
            b++;
        end
        ok = (starts.size() >= n);
    endtask

    task automatic wait_errs(input int n, input int budget, output bit ok);
        int b;
        b = 0;
        while (err_edges.size() < n && b < budget) begin
            tick();
            b++;
        end
        ok = (err_edges.size() >= n);
    endtask

    // Expected service order from the queued bytes, starting from pointer last0.
    task automatic build_expect(input int last0);
        int              h [NREQ];
        int              l;
        int              w;
        logic [NREQ-1:0] v;
        l = last0;
        for (int k = 0; k < NREQ; k++) h[k] = head[k];
        exp_w.delete();
        exp_d.delete();
        for (int n = 0; n < NREQ * QD; n++) begin
            for (int k = 0; k < NREQ; k++) v[k] = (h[k] < tail[k]);
            w = rr_pick(v, l);
            if (w < 0) break;
            exp_w.push_back(w);
            exp_d.push_back(bq[w][h[w]]);
            h[w]++;
            l = w;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.grant_o, bus.req_ack_o, bus.tx_data_o, bus.tx_start_o, bus.err_timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_async: got g=%b a=%b d=%h s=%b e=%b, required all 0",
                     bus.grant_o, bus.req_ack_o, bus.tx_data_o, bus.tx_start_o, bus.err_timeout_o);
        end
        tick();
        tick();
        checks++;
        if ({bus.grant_o, bus.req_ack_o, bus.tx_data_o, bus.tx_start_o, bus.err_timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_held: got g=%b a=%b s=%b, required all 0", bus.grant_o, bus.req_ack_o, bus.tx_start_o);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({bus.grant_o, bus.req_ack_o, bus.tx_start_o, bus.err_timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got g=%b a=%b s=%b e=%b, required all 0",
                     bus.grant_o, bus.req_ack_o, bus.tx_start_o, bus.err_timeout_o);
        end
    endtask

    task automatic test_single();
        int base, fb, p, f;
        bit ok;
        do_reset();
        base = starts.size();
        fb   = fall_edges.size();
        busy_len = 100;
        push_byte(2, 8'hA5);
        p = cyc;
        wait_starts(base + 1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_launch: got no launch, required one within 20 cycles"); end
        if (ok) begin
            checks++;
            if (starts[base].ack !== 4'b0100 || starts[base].start !== 1'b1) begin
                errors++;
                $display("FAIL single_ack: got ack=%b start=%b, required 0100/1", starts[base].ack, starts[base].start);
            end
            checks++;
            if (starts[base].data !== 8'hA5 || starts[base].grant !== 4'b0100) begin
                errors++;
                $display("FAIL single_data: got data=%h grant=%b, required a5/0100", starts[base].data, starts[base].grant);
            end
            checks++;
            if (starts[base].cyc !== p + 1) begin
                errors++;
                $display("FAIL single_latency: got edge %0d, required %0d", starts[base].cyc, p + 1);
            end
        end
        push_byte(1, 8'h3C);
        wait_starts(base + 2, 300, ok);
        checks++;
        if (!ok || fall_edges.size() <= fb) begin
            errors++;
            $display("FAIL single_second: got starts=%0d falls=%0d, required second launch after busy fall",
                     starts.size() - base, fall_edges.size() - fb);
        end else begin
            f = fall_edges[fb];
            checks++;
            if (starts[base+1].cyc !== f + GAP + 1) begin
                errors++;
                $display("FAIL single_gap: got next grant at %0d, required %0d", starts[base+1].cyc, f + GAP + 1);
            end
            checks++;
            if (grant_log[f+GAP-1] !== 4'b0100 || grant_log[f+GAP] !== 4'b0000) begin
                errors++;
                $display("FAIL single_grant_hold: got %b then %b, required 0100 then 0000",
                         grant_log[f+GAP-1], grant_log[f+GAP]);
            end
            checks++;
            if (starts[base+1].ack !== 4'b0010 || starts[base+1].data !== 8'h3C) begin
                errors++;
                $display("FAIL single_next: got ack=%b data=%h, required 0010/3c", starts[base+1].ack, starts[base+1].data);
            end
        end
    endtask

    // Compares launches starting at record base against exp_w/exp_d.
    task automatic test_order(input string name, input int base, input int fb, input bit timing);
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (base + i >= starts.size()) begin
                errors++;
                $display("FAIL %s_missing: got %0d launches, required %0d", name, starts.size() - base, exp_w.size());
                break;
            end
            if (starts[base+i].ack !== oh(exp_w[i]) || starts[base+i].grant !== oh(exp_w[i])
                || starts[base+i].data !== exp_d[i] || starts[base+i].start !== 1'b1) begin
                errors++;
                $display("FAIL %s_frame%0d: got ack=%b grant=%b data=%h, required %b/%b/%h",
                         name, i, starts[base+i].ack, starts[base+i].grant, starts[base+i].data,
                         oh(exp_w[i]), oh(exp_w[i]), exp_d[i]);
            end
            if (timing && i > 0) begin
                checks++;
                if (fb + i - 1 >= fall_edges.size() || starts[base+i].cyc !== fall_edges[fb+i-1] + GAP + 1) begin
                    errors++;
                    $display("FAIL %s_spacing%0d: got launch at %0d, required busy fall + %0d",
                             name, i, starts[base+i].cyc, GAP + 1);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int base, fb;
        bit ok;
        do_reset();
        base = starts.size();
        fb   = fall_edges.size();
        rand_len = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < ((k < 2) ? 2 : 1); j++) push_byte(k, 8'($urandom_range(0, 255)));
        end
        build_expect(NREQ - 1);
        wait_starts(base + exp_w.size(), 800, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_done: got %0d launches, required %0d", starts.size() - base, exp_w.size()); end
        test_order("rr", base, fb, 1'b1);
    endtask

    task automatic test_sparse();
        int base;
        bit ok;
        do_reset();
        base = starts.size();
        busy_len = 6;
        push_byte(2, 8'h11);
        wait_starts(base + 1, 20, ok);
        push_byte(0, 8'h22);
        push_byte(1, 8'h33);
        wait_starts(base + 3, 400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sparse_done: got %0d launches, required 3", starts.size() - base);
        end else begin
            checks++;
            if (starts[base+1].vseen !== 4'b0011 || starts[base+1].ack !== oh(rr_pick(4'b0011, 2))) begin
                errors++;
                $display("FAIL sparse_wrap: got valid=%b ack=%b, required 0011/%b",
                         starts[base+1].vseen, starts[base+1].ack, oh(rr_pick(4'b0011, 2)));
            end
            checks++;
            if (starts[base+2].ack !== 4'b0010 || starts[base+2].data !== 8'h33) begin
                errors++;
                $display("FAIL sparse_next: got ack=%b data=%h, required 0010/33", starts[base+2].ack, starts[base+2].data);
            end
        end
    endtask

    task automatic test_random();
        int base, fb, total, n;
        bit ok;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            base = starts.size();
            fb   = fall_edges.size();
            rand_len = 1'b1;
            total = 0;
            for (int k = 0; k < NREQ; k++) begin
                n = int'($urandom_range(0, 3));
                for (int j = 0; j < n; j++) push_byte(k, 8'($urandom_range(0, 255)));
                total += n;
            end
            if (total == 0) push_byte(int'($urandom_range(0, NREQ - 1)), 8'hE7);
            build_expect(NREQ - 1);
            n = err_edges.size();
            wait_starts(base + exp_w.size(), 60 * exp_w.size() + 40, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_done: got %0d launches, required %0d", starts.size() - base, exp_w.size()); end
            test_order("rand", base, fb, 1'b1);
            checks++;
            if (err_edges.size() !== n) begin
                errors++;
                $display("FAIL rand_noerr: got %0d timeouts, required 0", err_edges.size() - n);
            end
        end
    endtask

    task automatic test_no_busy_timeout();
        int base, eb, s;
        bit ok;
        do_reset();
        base = starts.size();
        eb   = err_edges.size();
        bm_mode = 1;
        push_byte(0, 8'h5A);
        push_byte(1, 8'h6B);
        wait_starts(base + 1, 20, ok);
        s = cyc;
        bm_mode  = 0;
        busy_len = 4;
        wait_starts(base + 2, TIMEOUT + 100, ok);
        checks++;
        if (!ok || err_edges.size() !== eb + 1) begin
            errors++;
            $display("FAIL tmo_count: got launches=%0d timeouts=%0d, required 2/1", starts.size() - base, err_edges.size() - eb);
        end else begin
            checks++;
            if (err_edges[eb] !== s + TIMEOUT) begin
                errors++;
                $display("FAIL tmo_time: got pulse at %0d, required %0d", err_edges[eb], s + TIMEOUT);
            end
            checks++;
            if (starts[base+1].cyc !== err_edges[eb] + GAP + 1 || starts[base+1].ack !== 4'b0010) begin
                errors++;
                $display("FAIL tmo_next: got edge %0d ack=%b, required %0d/0010",
                         starts[base+1].cyc, starts[base+1].ack, err_edges[eb] + GAP + 1);
            end
        end
        repeat (40) tick();
        checks++;
        if (err_edges.size() !== eb + 1) begin
            errors++;
            $display("FAIL tmo_recover: got %0d timeouts, required 1", err_edges.size() - eb);
        end
    endtask

    task automatic test_stuck_busy();
        int base, eb, rb, r;
        bit ok;
        do_reset();
        base = starts.size();
        eb   = err_edges.size();
        rb   = rise_edges.size();
        bm_mode = 2;
        push_byte(2, 8'h77);
        wait_starts(base + 1, 20, ok);
        wait_errs(eb + 1, TIMEOUT + 50, ok);
        checks++;
        if (!ok || rise_edges.size() <= rb) begin
            errors++;
            $display("FAIL stuck_pulse: got timeouts=%0d rises=%0d, required 1/1", err_edges.size() - eb, rise_edges.size() - rb);
        end else begin
            checks++;
            if (err_edges[eb] !== rise_edges[rb] + TIMEOUT) begin
                errors++;
                $display("FAIL stuck_time: got pulse at %0d, required %0d", err_edges[eb], rise_edges[rb] + TIMEOUT);
            end
        end
        bm_mode  = 0;
        busy_len = 3;
        push_byte(0, 8'h01);
        repeat (GAP + 40) tick();
        checks++;
        if (starts.size() !== base + 1) begin
            errors++;
            $display("FAIL stuck_hold: got %0d launches while busy, required 1", starts.size() - base);
        end
        busy_off_at   = cyc;
        bus.tx_busy_i = 1'b0;
        r = cyc;
        wait_starts(base + 2, 10, ok);
        checks++;
        if (!ok || starts[base+1].cyc !== r + 1 || starts[base+1].ack !== 4'b0001) begin
            errors++;
            $display("FAIL stuck_release: got launches=%0d, required ack 0001 at edge %0d", starts.size() - base, r + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, eb, p;
        bit ok;
        do_reset();
        base = starts.size();
        busy_len = 100;
        push_byte(1, 8'hC3);
        wait_starts(base + 1, 20, ok);
        repeat (10) tick();
        eb = err_edges.size();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.grant_o, bus.req_ack_o, bus.tx_data_o, bus.tx_start_o, bus.err_timeout_o} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got g=%b d=%h s=%b, required all 0", bus.grant_o, bus.tx_data_o, bus.tx_start_o);
        end
        clear_model();
        tick();
        tick();
        reset_n = 1'b1;
        base = starts.size();
        push_byte(3, 8'h9E);
        p = cyc;
        wait_starts(base + 1, 20, ok);
        checks++;
        if (!ok || starts[base].ack !== 4'b1000 || starts[base].cyc !== p + 1 || starts[base].data !== 8'h9E) begin
            errors++;
            $display("FAIL midreset_grant: got launches=%0d, required ack 1000 data 9e at edge %0d", starts.size() - base, p + 1);
        end
        repeat (30) tick();
        checks++;
        if (starts.size() !== base + 1 || err_edges.size() !== eb) begin
            errors++;
            $display("FAIL midreset_clean: got extra launches=%0d timeouts=%0d, required 0/0",
                     starts.size() - base - 1, err_edges.size() - eb);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        grant_log.push_back('0);
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.tx_busy_i   = 1'b0;
        clear_model();
        #2;
        reset_n = 1'b0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_sparse();
        test_random();
        test_no_busy_timeout();
        test_stuck_busy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter between NREQ byte-producing requesters.
- Accepts one byte at a time from a requester and launches it with a single-cycle start strobe.
- Waits for the transmitter to finish the frame, then enforces a programmable inter-frame gap.
- Flags a stalled transmitter with a timeout pulse instead of hanging.

Parameters:
NREQ, 4, number of requesters (1..8)
GAP, 16, idle sysclk cycles inserted after each frame before the next grant (0 = no gap)
TIMEOUT, 4096, max sysclk cycles spent in WAIT_BUSY or WAIT_DONE before abort (>=2)

Ports:
sysclk  in  1  system clock, rising edge
reset_n  in  1  reset, asynchronous assert, active-low
req_valid_i  in  NREQ  bit k: requester k has a byte pending
req_data_i  in  8*NREQ  byte of requester k on bits [8k+7:8k]
req_ack_o  out  NREQ  one-hot, 1-cycle pulse: byte of requester k accepted
grant_o  out  NREQ  one-hot owner of the transmitter for the current frame; 0 when idle
tx_data_o  out  8  byte to the transmitter, stable from launch until return to IDLE
tx_start_o  out  1  1-cycle launch strobe to the transmitter
tx_busy_i  in  1  transmitter is shifting a frame
err_timeout_o  out  1  1-cycle pulse: transmitter did not respond or did not finish

Behaviour:
- All outputs are registered.
- Reset (reset_n=0, asynchronous) sets:
  - state to IDLE
  - req_ack_o, grant_o, tx_data_o, tx_start_o, err_timeout_o to 0
  - round-robin pointer last to NREQ-1, so requester 0 has first priority
  - gap and timeout counters to 0
- Reset mid-frame abandons the frame. No ack is repeated and no error is reported.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Arbitrates when |req_valid_i=1 and tx_busy_i=0. No grant while tx_busy_i=1.
  - Winner w is the first set bit of req_valid_i searching last+1, last+2, ... modulo NREQ.
  - At that edge: tx_data_o<=req_data_i[w]; grant_o<=onehot(w); req_ack_o<=onehot(w); tx_start_o<=1; last<=w; timer<=0; state<=WAIT_BUSY.
  - req_ack_o and tx_start_o are high together for exactly one cycle, the cycle after valid is sampled. The next edge clears both.
- Requester handshake:
  - A requester holds valid and data stable until it sees ack. It may drop valid or present the next byte in the ack cycle.
  - req_valid_i is ignored outside IDLE.
  - Only the value sampled at the IDLE edge counts. A valid that drops in the same cycle is not granted.
- WAIT_BUSY:
  - On tx_busy_i=1: timer<=0, state<=WAIT_DONE.
  - Otherwise timer increments. When timer==TIMEOUT-1, pulse err_timeout_o and go to GAP.
- WAIT_DONE:
  - On tx_busy_i=0, go to GAP.
  - Otherwise timer increments. When timer==TIMEOUT-1, pulse err_timeout_o and go to GAP.
- GAP:
  - On entry gap counter=0; it increments each cycle.
  - When the counter reaches GAP-1: grant_o<=0, state<=IDLE.
  - GAP=0: WAIT_DONE and the timeout paths go directly to IDLE and clear grant_o.
- The timeout path still applies the gap. grant_o stays set until IDLE is re-entered.
- Width rules:
  - Timer and gap counters are sized with $clog2 to hold TIMEOUT-1 and GAP-1. No wrap occurs inside a state.
  - The pointer is $clog2(NREQ) bits with explicit modulo wrap. NREQ=1 always grants requester 0.
- Fairness: a requester holding valid continuously is served within NREQ frames.
- Default-parameter throughput: back-to-back frames from different requesters are separated by exactly GAP cycles of tx_busy_i=0 between frames, plus 1 arbitration cycle.
- Illegal state encodings return to IDLE with all outputs cleared.

Test Plan:
- Reset then single request: req_valid_i=4'b0100, data[23:16]=8'hA5; busy model rises 2 cycles after start and stays high 100 cycles. Required: ack=4'b0100 and tx_start_o together, 1 cycle after sampling; tx_data_o=8'hA5; grant_o=4'b0100 until IDLE; next grant exactly GAP+1 cycles after busy falls.
- Round robin: req_valid_i=4'b1111 held (each requester re-asserts after ack). Required: grant order 0,1,2,3,0,1; no requester served twice before the others.
- Sparse contention: last=2, req_valid_i=4'b0011. Required: requester 0 wins (wraps past 3), then requester 1.
- Transmitter never asserts busy. Required: err_timeout_o pulses once, exactly TIMEOUT cycles after tx_start_o; GAP applied; next pending request then granted normally.
- tx_busy_i stuck high after start. Required: timeout pulse TIMEOUT cycles after busy rose. Then tx_busy_i held high in IDLE with req_valid_i=4'b0001: no ack until busy drops.
- reset_n asserted mid-WAIT_DONE. Required: outputs 0 asynchronously. After release, req_valid_i=4'b1000 is granted to requester 3 with the pointer reset (requester 0 would win if also valid).
